bcd_conv_arbiter: RTL
=====================

Name: bcd_conv_arbiter

Overview:
- Shares one Binary_to_BCD converter between NUM_REQ requesters, for example several display or readout channels.
- Arbitrates pending requests round-robin and launches one conversion at a time with a single-cycle start.
- Waits for the converter's data-valid pulse and returns the BCD result to the granted requester with a done pulse.
- A watchdog aborts a conversion that never completes and flags an error to the requester.

Parameters:
- NUM_REQ, 4: number of requesters; at least 2.
- INPUT_WIDTH, 14: binary operand width; must match the converter.
- DECIMAL_DIGITS, 4: BCD digit count; must match the converter.
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before abort; must be ≥ 1 and exceed the worst-case converter latency.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Req  in  NUM_REQ  per-requester level request; held high until that requester's o_Ack.
- i_Req_Binary  in  NUM_REQ*INPUT_WIDTH  operands; requester k uses slice [k*INPUT_WIDTH +: INPUT_WIDTH]; stable while i_Req[k] is high.
- o_Ack  out  NUM_REQ  one-hot, one-cycle pulse: operand captured.
- o_Done  out  NUM_REQ  one-hot, one-cycle pulse: result or error valid.
- o_Result_BCD  out  DECIMAL_DIGITS*4  result; valid only while any o_Done bit is high.
- o_Err  out  1  high with o_Done when the conversion timed out; o_Result_BCD is then 0.
- o_Busy  out  1  high in every state except IDLE.
- o_Conv_Start  out  1  to converter i_Start.
- o_Conv_Binary  out  INPUT_WIDTH  to converter i_Binary.
- i_Conv_BCD  in  DECIMAL_DIGITS*4  from converter o_BCD.
- i_Conv_DV  in  1  from converter o_DV.

Behaviour:
- Reset (asynchronous, i_Reset=1):
  - state=IDLE, round-robin pointer=0, grant index=0, operand register=0, result register=0, timeout counter=0.
  - All outputs 0.
  - Reset asserted mid-conversion abandons it with no o_Done. A later i_Conv_DV arriving in IDLE is ignored.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - If any i_Req bit is set, select the first set bit at or after the pointer, scanning upward with wrap-around.
  - At that edge: register grant index k, latch operand slice k, go to START.
  - If no request is set, stay in IDLE. i_Conv_DV is ignored.
- START (exactly 1 cycle):
  - o_Ack[k]=1 and o_Conv_Start=1; o_Conv_Binary=latched operand (driven from the register in all states).
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - o_Conv_Start=0; the counter increments each cycle.
  - If i_Conv_DV=1: latch i_Conv_BCD into the result register, clear the error flag, go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: set the error flag, clear the result register, go to DONE.
  - If i_Conv_DV and the timeout condition occur in the same cycle, i_Conv_DV wins: no error.
- DONE (exactly 1 cycle):
  - o_Done[k]=1, o_Result_BCD=result register, o_Err=error flag.
  - Pointer ← (k+1) mod NUM_REQ. Go to IDLE.
- Latency:
  - i_Req rise seen in IDLE → o_Ack one cycle later.
  - o_Done follows i_Conv_DV by one cycle.
  - Back-to-back grants: next START is 2 cycles after DONE (DONE → IDLE → START).
- Arbitration:
  - At most one transaction is in flight.
  - The pointer advances only on completion (including errors).
  - A requester that drops i_Req before its ack is simply not selected.
  - i_Req[k] high during its own o_Ack cycle is not seen as a new request, because the arbiter is not in IDLE then. The requester deasserts on o_Ack.
- Widths:
  - Timeout counter width is $clog2(TIMEOUT_CYCLES+1).
  - Grant index width is $clog2(NUM_REQ).
  - No arithmetic is done on BCD data.
- Converter contract: o_Conv_Start is asserted only in START, which the converter accepts in its own IDLE state. The arbiter never re-starts the converter before DV or timeout.

Test Plan:
- Reset, then requester 1 requests 1234 (INPUT_WIDTH=14, DECIMAL_DIGITS=4, real converter) → o_Ack=0010 for one cycle; later o_Done=0010 with o_Result_BCD=16'h1234, o_Err=0; o_Busy returns to 0.
- Requesters 0 and 2 request 9999 and 0 in the same cycle → served 0 then 2; results 16'h9999 then 16'h0000; pointer ends at 3. A new request on 0 and 3 then serves 3 first.
- Converter replaced by a stub that never asserts DV, TIMEOUT_CYCLES=16 → o_Done[k]=1 with o_Err=1, o_Result_BCD=0, exactly 17 cycles after the START cycle; next request is then served normally.
- Stub asserts DV on the same cycle the counter reaches TIMEOUT_CYCLES-1, with BCD 16'h0042 → o_Err=0, o_Result_BCD=16'h0042.
- i_Reset pulsed asynchronously (mid-cycle) during WAIT → all outputs 0 immediately; no o_Done for the aborted request; a stray i_Conv_DV afterwards produces no o_Done.
- All four requesters held high continuously → grants rotate 0,1,2,3,0; exactly one o_Conv_Start per o_Done; never two conversions in flight.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: shares one Binary_to_BCD converter among NUM_REQ requesters.
// Round-robin grant, one conversion in flight, watchdog abort with error flag.
module bcd_conv_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int INPUT_WIDTH    = 14,
   parameter int DECIMAL_DIGITS = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                              i_Clock,
   input  logic                              i_Reset,
   input  logic [NUM_REQ-1:0]                i_Req,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0]    i_Req_Binary,
   output logic [NUM_REQ-1:0]                o_Ack,
   output logic [NUM_REQ-1:0]                o_Done,
   output logic [DECIMAL_DIGITS*4-1:0]       o_Result_BCD,
   output logic                              o_Err,
   output logic                              o_Busy,
   output logic                              o_Conv_Start,
   output logic [INPUT_WIDTH-1:0]            o_Conv_Binary,
   input  logic [DECIMAL_DIGITS*4-1:0]       i_Conv_BCD,
   input  logic                              i_Conv_DV
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BCD_W = DECIMAL_DIGITS * 4;

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [INPUT_WIDTH-1:0] operand_q, operand_d;
   logic [BCD_W-1:0]       result_q, result_d;
   logic                   err_q, err_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic [NUM_REQ-1:0]     done_q, done_d;
   logic                   start_q, start_d;

   logic [INPUT_WIDTH-1:0] req_bin [NUM_REQ];
   logic                   req_found;
   logic [IDX_W-1:0]       req_idx;

   // Unpack the flat operand bus so the granted slice can be picked by index
   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         req_bin[k] = i_Req_Binary[k*INPUT_WIDTH +: INPUT_WIDTH];
      end
   end

   // Round-robin pick: first pending request at or above the pointer, wrapping
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      req_found = 1'b0;
      req_idx   = ptr_q;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!req_found && i_Req[cand_idx]) begin
            req_found = 1'b1;
            req_idx   = cand_idx;
         end
      end
   end

   // Next-state and next-output computation; pulses default low every cycle
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      operand_d = operand_q;
      result_d  = result_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      ack_d     = '0;
      done_d    = '0;
      start_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Converter DV is deliberately ignored here (stale pulses after reset)
            if (req_found) begin
               grant_d        = req_idx;
               operand_d      = req_bin[req_idx];
               ack_d[req_idx] = 1'b1;
               start_d        = 1'b1;
               state_d        = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // DV takes priority over a coincident timeout
            if (i_Conv_DV) begin
               result_d        = i_Conv_BCD;
               err_d           = 1'b0;
               done_d[grant_q] = 1'b1;
               state_d         = S_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               result_d        = '0;
               err_d           = 1'b1;
               done_d[grant_q] = 1'b1;
               state_d         = S_DONE;
            end
         end
         S_DONE: begin
            // Pointer moves only on completion, to the requester after the winner
            ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         operand_q <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         ack_q     <= '0;
         done_q    <= '0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         operand_q <= operand_d;
         result_q  <= result_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         start_q   <= start_d;
      end
   end

   assign o_Ack         = ack_q;
   assign o_Done        = done_q;
   assign o_Conv_Start  = start_q;
   assign o_Conv_Binary = operand_q;
   assign o_Busy        = (state_q != S_IDLE);
   // Result and error are only meaningful alongside the done pulse
   assign o_Result_BCD  = (state_q == S_DONE) ? result_q : '0;
   assign o_Err         = (state_q == S_DONE) & err_q;

endmodule
